// File: rtl/falu_pkg.sv
// Shared types and constants for the falu floating-point ALU and its issue front-end.
package falu_pkg;

  localparam logic [1:0] FALU_ADD = 2'b00;
  localparam logic [1:0] FALU_SUB = 2'b01;
  localparam logic [1:0] FALU_MUL = 2'b10;
  localparam logic [1:0] FALU_DIV = 2'b11;

  typedef logic [1:0]  falu_op_t;
  typedef logic [31:0] fp32_t;

  // Tag is kept outside the struct so its width can stay a module parameter.
  typedef struct packed {
    falu_op_t op;
    fp32_t    a;
    fp32_t    b;
  } falu_cmd_t;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_W   = 23;

endpackage

// File: rtl/falu_issue_if.sv
// Command/result handshake bundle for falu_issue.
// Carries res_exc only when FALU_ISSUE_EXC_EN is defined.
interface falu_issue_if
  import falu_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  falu_op_t         cmd_op;
  fp32_t            cmd_a;
  fp32_t            cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic             res_valid;
  logic             res_ready;
  fp32_t            res_data;
  falu_op_t         res_op;
  logic [TAG_W-1:0] res_tag;
`ifdef FALU_ISSUE_EXC_EN
  logic [2:0]       res_exc;

  modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, res_ready,
                  input  cmd_ready, res_valid, res_data, res_op, res_tag, res_exc);
  modport slave  (input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, res_ready,
                  output cmd_ready, res_valid, res_data, res_op, res_tag, res_exc);
`else
  modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, res_ready,
                  input  cmd_ready, res_valid, res_data, res_op, res_tag);
  modport slave  (input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, res_ready,
                  output cmd_ready, res_valid, res_data, res_op, res_tag);
`endif
endinterface

// File: rtl/falu.sv
// Combinational single-precision ALU: add, sub, mul, div.
// Denormal inputs are treated as zero, results are truncated (round toward zero),
// overflow saturates to infinity and underflow flushes to signed zero.
module falu
  import falu_pkg::*;
(
  input  falu_op_t op,
  input  fp32_t    b,
  input  fp32_t    c,
  output fp32_t    y
);
  localparam fp32_t QNAN = 32'h7fc0_0000;

  function automatic fp32_t fp_pack(input logic s, input logic signed [10:0] e,
                                    input logic [MAN_W-1:0] m);
    if (e >= 11'sd255)    return {s, 8'hff, 23'h0};
    else if (e <= 11'sd0) return {s, 31'h0};
    else                  return {s, e[7:0], m};
  endfunction

  logic       sb, sc, sx;
  logic [7:0] eb, ec;
  logic [23:0] mb, mc;
  logic       nan_b, nan_c, inf_b, inf_c, zero_b, zero_c;

  assign sb     = b[31];
  assign sc     = c[31] ^ (op == FALU_SUB);
  assign sx     = b[31] ^ c[31];
  assign eb     = b[EXP_MSB:EXP_LSB];
  assign ec     = c[EXP_MSB:EXP_LSB];
  assign mb     = {1'b1, b[MAN_W-1:0]};
  assign mc     = {1'b1, c[MAN_W-1:0]};
  assign nan_b  = (&eb) && (|b[MAN_W-1:0]);
  assign nan_c  = (&ec) && (|c[MAN_W-1:0]);
  assign inf_b  = (&eb) && !(|b[MAN_W-1:0]);
  assign inf_c  = (&ec) && !(|c[MAN_W-1:0]);
  assign zero_b = (eb == 8'd0);
  assign zero_c = (ec == 8'd0);

  logic              big_b, s_big, s_sml;
  logic [7:0]        e_big, d;
  logic [23:0]       m_big, m_sml;
  logic [26:0]       x_sml, norm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [10:0] e_add, e_mul, e_div;
  logic [47:0]       prod, quo;
  fp32_t             y_add, y_mul, y_div;

  // Add/sub: align the smaller magnitude with 3 guard bits, then renormalise.
  always_comb begin
    big_b = {eb, mb} >= {ec, mc};
    s_big = big_b ? sb : sc;
    s_sml = big_b ? sc : sb;
    e_big = big_b ? eb : ec;
    d     = big_b ? (eb - ec) : (ec - eb);
    m_big = big_b ? mb : mc;
    m_sml = big_b ? mc : mb;
    x_sml = {m_sml, 3'b000} >> d;
    if (s_big == s_sml) sum = {1'b0, m_big, 3'b000} + {1'b0, x_sml};
    else                sum = {1'b0, m_big, 3'b000} - {1'b0, x_sml};
    lz = '0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    if (sum[27]) begin
      norm  = sum[27:1];
      e_add = $signed({3'b0, e_big}) + 11'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      e_add = $signed({3'b0, e_big}) - $signed({6'b0, lz});
    end
    if (nan_b || nan_c || (inf_b && inf_c && (sb != sc))) y_add = QNAN;
    else if (inf_b)               y_add = {sb, 8'hff, 23'h0};
    else if (inf_c)               y_add = {sc, 8'hff, 23'h0};
    else if (zero_b && zero_c)    y_add = {sb & sc, 31'h0};
    else if (zero_b)              y_add = {sc, c[30:0]};
    else if (zero_c)              y_add = b;
    else if (sum == 28'd0)        y_add = '0;
    else                          y_add = fp_pack(s_big, e_add, norm[25:3]);
  end

  // Mul/div: 24x24 product and 48/24 quotient, one normalisation step each.
  always_comb begin
    prod  = {24'b0, mb} * {24'b0, mc};
    quo   = {mb, 24'b0} / {24'b0, mc};
    e_mul = $signed({3'b0, eb}) + $signed({3'b0, ec}) - 11'sd127 + $signed({10'b0, prod[47]});
    e_div = $signed({3'b0, eb}) - $signed({3'b0, ec}) + 11'sd126 + $signed({10'b0, quo[24]});
    if (nan_b || nan_c || (inf_b && zero_c) || (zero_b && inf_c)) y_mul = QNAN;
    else if (inf_b || inf_c)   y_mul = {sx, 8'hff, 23'h0};
    else if (zero_b || zero_c) y_mul = {sx, 31'h0};
    else y_mul = fp_pack(sx, e_mul, prod[47] ? prod[46:24] : prod[45:23]);
    if (nan_b || nan_c || (zero_b && zero_c) || (inf_b && inf_c)) y_div = QNAN;
    else if (inf_b || zero_c)  y_div = {sx, 8'hff, 23'h0};
    else if (zero_b || inf_c)  y_div = {sx, 31'h0};
    else y_div = fp_pack(sx, e_div, quo[24] ? quo[23:1] : quo[22:0]);
  end

  // Operation select.
  always_comb begin
    y = y_add;
    if (op == FALU_MUL)      y = y_mul;
    else if (op == FALU_DIV) y = y_div;
  end

  logic unused_bits;
  assign unused_bits = ^{norm[26], norm[2:0], prod[22:0], quo[47:25]};

endmodule

// File: rtl/falu_cmd_fifo.sv
// Synchronous FIFO; pointers carry one extra bit so full and empty differ.
// Caller must not push when full nor pop when empty.
module falu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  // Pointer advance and entry write.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
  end

  // Pointer registers; reset discards contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only read between pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/falu_issue.sv
// Clocked, in-order, back-pressurable front-end for the falu ALU.
// Optional macro FALU_ISSUE_EXC_EN adds a registered NaN/Inf/zero flag (res_exc).
module falu_issue
  import falu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  falu_issue_if.slave      io,
  output logic             busy,
  output logic [CNT_W-1:0] issued_cnt
);
  localparam int ENT_W = $bits(falu_cmd_t) + TAG_W;

  logic             push, pop, full, empty;
  falu_cmd_t        cmd_in, head_cmd;
  logic [TAG_W-1:0] head_tag;
  logic [ENT_W-1:0] head;
  fp32_t            falu_y;

  logic             res_valid_q, res_valid_d;
  fp32_t            res_data_q, res_data_d;
  falu_op_t         res_op_q, res_op_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cmd_in  = '{op: io.cmd_op, a: io.cmd_a, b: io.cmd_b};
  // Ready looks only at full, never at this cycle's pop.
  assign io.cmd_ready = !full;
  assign push    = io.cmd_valid && !full;
  assign pop     = !empty && (!res_valid_q || io.res_ready);
  assign {head_cmd, head_tag} = head;

  falu_cmd_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  ({cmd_in, io.cmd_tag}),
    .pop  (pop),
    .head (head),
    .full (full),
    .empty(empty)
  );

  falu u_falu (
    .op(head_cmd.op),
    .b (head_cmd.a),
    .c (head_cmd.b),
    .y (falu_y)
  );

  // Result register load on issue, release when drained with nothing behind it.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_tag_d   = res_tag_q;
    cnt_d       = cnt_q;
    if (pop) begin
      res_valid_d = 1'b1;
      res_data_d  = falu_y;
      res_op_d    = head_cmd.op;
      res_tag_d   = head_tag;
      cnt_d       = cnt_q + 1'b1;
    end else if (res_valid_q && io.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Result and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_tag_q   <= '0;
      cnt_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_tag_q   <= res_tag_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef FALU_ISSUE_EXC_EN
  logic [2:0] exc_q, exc_d;
  logic       y_exp_ones, y_man_nz;

  assign y_exp_ones = &falu_y[EXP_MSB:EXP_LSB];
  assign y_man_nz   = |falu_y[MAN_W-1:0];

  // Classify the issued result alongside res_data.
  always_comb begin
    exc_d = exc_q;
    if (pop) exc_d = {y_exp_ones && y_man_nz, y_exp_ones && !y_man_nz,
                      !(|falu_y[30:0])};
  end

  // Class flag register.
  always_ff @(posedge clk) begin
    if (rst) exc_q <= '0;
    else     exc_q <= exc_d;
  end

  assign io.res_exc = exc_q;
`endif

  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign io.res_op    = res_op_q;
  assign io.res_tag   = res_tag_q;
  assign busy         = !empty || res_valid_q;
  assign issued_cnt   = cnt_q;

endmodule

// File: doc/falu_issue.md
Name: falu_issue

Overview:
- Sequential front-end that feeds the combinational `falu` floating-point ALU.
- Accepts (op, a, b, tag) commands over a valid/ready interface and buffers them in a small in-order FIFO.
- Issues the FIFO head to an internal `falu` instance and registers the result with its tag for a downstream valid/ready consumer (e.g. the neuron update stage).
- Removes the bench-style "poke inputs, wait #1" usage: results become clocked, ordered and back-pressurable.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.
- TAG_W, 4, width of the opaque tag carried from command to result.
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- cmd_a  in  32  IEEE-754 single operand b (first falu operand).
- cmd_b  in  32  IEEE-754 single operand c (second falu operand).
- cmd_tag  in  TAG_W  caller tag.
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer takes the result.
- res_data  out  32  falu output for the issued command.
- res_op  out  2  op of the issued command.
- res_tag  out  TAG_W  tag of the issued command.
- busy  out  1  FIFO non-empty or res_valid.
- issued_cnt  out  CNT_W  count of commands issued to the result register.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: FIFO empty (pointers 0), res_valid=0, res_data=0, res_op=0, res_tag=0, issued_cnt=0, busy=0. cmd_ready=1 combinationally from the cycle after reset.
- Reset mid-operation: all queued and registered commands are discarded silently; nothing drains.
- Accept: a command is taken on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready = !fifo_full. It does not depend on pop in the same cycle, so there is no ready-through combinational path.
- Issue: pop = !fifo_empty && (!res_valid || res_ready).
  - The FIFO head drives the falu inputs combinationally.
  - On a pop edge: res_data <= falu_out, res_op/res_tag <= head fields, res_valid <= 1, issued_cnt <= issued_cnt+1.
- Drain: if res_valid && res_ready && fifo_empty, then res_valid <= 0. res_data/res_op/res_tag hold their last values.
- Latency: a command accepted at edge k into an empty FIFO with a free result register gives res_valid=1 after edge k+1.
  - Throughput is one result per cycle while res_ready=1.
- Capacity: FIFO_DEPTH+1 outstanding commands (FIFO plus result register).
- Ordering: strictly in order; no reordering by op.
- Simultaneous push and pop: allowed when not full; occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- Full and empty are distinguished with an extra pointer bit.
- issued_cnt wraps from 2^CNT_W−1 to 0.
- Arithmetic: results are bit-identical to the falu combinational output for the same (op, b, c). falu_issue does no rounding or special-case handling of its own.
- Output stability: while res_valid && !res_ready, res_data/res_op/res_tag are stable.

Optional Feature:
- Macro: FALU_ISSUE_EXC_EN.
- Defined: adds output res_exc [2:0], registered with res_data on every pop.
  - res_exc[2] = NaN: exponent all ones, mantissa ≠ 0.
  - res_exc[1] = Inf: exponent all ones, mantissa 0.
  - res_exc[0] = zero: exponent and mantissa 0, either sign.
  - res_exc resets to 0.
- Undefined: no res_exc port and no classification logic; all other behaviour is identical.

Decomposition:
- Package falu_pkg:
  - localparams FALU_ADD=2'b00, FALU_SUB=2'b01, FALU_MUL=2'b10, FALU_DIV=2'b11.
  - typedef falu_op_t (logic [1:0]) and fp32_t (logic [31:0]).
  - struct falu_cmd_t {op, a, b}; the tag stays a separate parameterised field.
  - FP32 field constants: EXP_MSB=30, EXP_LSB=23, MAN_W=23.
- Sub-module falu_cmd_fifo: synchronous FIFO parameterised by width and depth, exposing full/empty/push/pop/head.
- The existing falu is instantiated unchanged.

Test Plan:
- Single op: rst, then cmd ADD a=3f800000 b=40000000 tag=3 → res_valid=1 exactly one cycle after accept; res_data=40400000, res_tag=3, issued_cnt=1.
- Stream: MUL 40400000×40000000 (tag 1), SUB 40400000−3f800000 (tag 2), DIV 40c00000/40000000 (tag 3), res_ready=1 → results 40c00000, 40000000, 40400000 in tag order on consecutive cycles.
- Backpressure: res_ready=0, push 7 commands with FIFO_DEPTH=4 → 5 accepted, cmd_ready=0 after the 5th. Then raise res_ready → 5 results in order; res_data held stable while stalled; cmd_ready=1 after the first pop.
- Mid-operation reset: 3 commands queued, rst for 1 cycle → res_valid=0, busy=0, issued_cnt=0; none of the old tags appear afterwards.
- Wrap: 2^CNT_W+2 ADDs with CNT_W=4 → issued_cnt=2; FIFO pointers wrap with no lost or duplicated tags.
- FALU_ISSUE_EXC_EN: ADD 7f800000+3f800000 → res_data=7f800000, res_exc=3'b010; SUB 3f800000−3f800000 → res_exc=3'b001.
